dmem_lsu_ctrl: RTL and testbench
================================

Name: dmem_lsu_ctrl

Overview:
Controller between the load/store unit and the 256x32 dual-port data SRAM `dmem` (port 0 write-only with byte mask, port 1 read-only).
- Buffers committed stores in a small in-order store queue and drains them to port 0.
- Issues loads to port 1 with tagged, fixed-latency responses.
- Resolves read-after-write hazards so the SRAM never sees a same-address read and write in one cycle.
- Generates all SRAM chip-select, mask, address and data signals.

Parameters:
ADDR_WIDTH, 8, SRAM word address width.
DATA_WIDTH, 32, word width.
NUM_WMASKS, 4, byte-enable count (DATA_WIDTH/8).
SQ_DEPTH, 4, store-queue entries (power of 2, at least 2).
TAG_W, 6, load tag width.

Ports:
clk  in  1  clock; SRAM clk0/clk1 tie to the same net.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  kill all in-flight loads.
wr_pause  in  1  hold store drain.
st_valid  in  1  store request.
st_ready  out  1  store accepted when st_valid & st_ready.
st_addr  in  ADDR_WIDTH  store word address.
st_data  in  DATA_WIDTH  store data.
st_mask  in  NUM_WMASKS  byte enables.
ld_valid  in  1  load request.
ld_ready  out  1  load accepted when ld_valid & ld_ready.
ld_addr  in  ADDR_WIDTH  load word address.
ld_tag  in  TAG_W  load tag.
rsp_valid  out  1  load data valid; no backpressure.
rsp_tag  out  TAG_W  tag of the returning load.
rsp_data  out  DATA_WIDTH  load data.
sq_empty  out  1  store queue empty and no write in flight.
mem_csb0  out  1  port-0 chip select, active low.
mem_wmask0  out  NUM_WMASKS  port-0 byte mask.
mem_addr0  out  ADDR_WIDTH  port-0 address.
mem_din0  out  DATA_WIDTH  port-0 write data.
mem_csb1  out  1  port-1 chip select, active low.
mem_addr1  out  ADDR_WIDTH  port-1 address.
mem_dout1  in  DATA_WIDTH  port-1 read data.

Behaviour:
- Reset: queue empty, pointers 0. st_ready=1, ld_ready=1, rsp_valid=0, rsp_tag=0, rsp_data=0, sq_empty=1. mem_csb0=1, mem_csb1=1, mem_wmask0=0, mem_addr0/din0/addr1=0. Reset mid-operation discards queued stores and in-flight loads.
- Store enqueue: st_ready = !full; no same-cycle bypass when full. A store with st_mask==0 is accepted and dropped, not enqueued.
- Store drain: when the queue is non-empty and wr_pause=0, the head drives mem_csb0=0, mem_addr0, mem_din0 and mem_wmask0 combinationally. The head pops that cycle (SRAM registers it at the edge and writes at the following negedge). Otherwise mem_csb0=1 and mem_wmask0=0. Minimum enqueue-to-write-drive latency is 1 cycle.
- Simultaneous enqueue and pop: both occur and the count is unchanged. Pointers wrap modulo SQ_DEPTH. Full and empty are decided by a count register.
- Load hazard: ld_ready=0 when flush=1, or when ld_addr matches any valid queue entry, including the head being driven this cycle.
  - A store arriving in the same cycle is younger and is not checked.
  - While paused with a matching entry, the load stalls until that entry drains.
- Load issue: on accept, mem_csb1=0 and mem_addr1=ld_addr combinationally; otherwise mem_csb1=1.
- Load pipeline: stage S1 holds {valid, tag}. Stage S2 samples mem_dout1 at the next edge.
- Load response: rsp_valid/rsp_tag/rsp_data are registered and asserted 2 cycles after acceptance (accept in cycle N, response in N+2). Throughput is 1 load/cycle, and back-to-back responses are allowed.
- Flush: clears S1 and S2 valid bits at the edge, so no response for any load accepted in or before the flush cycle. The queue is unaffected and stores keep draining.
- sq_empty: 1 when count==0 and no write was driven in the current cycle.

Decomposition:
- Package dmem_lsu_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH/NUM_WMASKS defaults.
  - sq_entry_t struct {addr, data, mask}.
  - ld_pipe_t {valid, tag}.
- One sub-module, dmem_store_queue: circular FIFO with per-entry valid. It exposes head, push/pop, full/empty, count, and a combinational match_any(addr) CAM output.
- The top holds the hazard logic, SRAM drive and the 2-stage load pipe.

Test Plan:
1. Store addr 0x10, data 0xDEADBEEF, mask 0xF; load 0x10 two cycles later -> rsp_data=0xDEADBEEF at accept+2, tag echoed.
2. Store 0x20 with mask 0x3 over a prior 0xFFFFFFFF, data 0x12345678 -> later load returns 0xFFFF5678.
3. wr_pause=1; push 4 stores -> st_ready=0 on the 5th. Load to a queued address -> ld_ready=0 until pause drops and that entry drains. Non-matching load issues immediately.
4. Store to 0x30 in the queue head plus load to 0x30 in the same cycle -> load stalls 1 cycle and returns the new data. Mem_csb0 and mem_csb1 are never both 0 with equal addresses.
5. Loads tags 1,2,3 back-to-back, flush in cycle of tag 3 accept -> tag 1 response only if it reached rsp already. Tags 2 and 3 never appear. The queue still drains.
6. Assert rst_n=0 with 3 queued stores and 2 loads in flight -> all outputs at reset values immediately. After release sq_empty=1 and no SRAM write occurs.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared widths and record types for the data-memory load/store controller.
package dmem_lsu_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int NUM_WMASKS_DEF = DATA_WIDTH_DEF / 8;
   localparam int TAG_W_DEF      = 6;

   // One buffered store: word address, write data, byte enables
   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [DATA_WIDTH_DEF-1:0] data;
      logic [NUM_WMASKS_DEF-1:0] mask;
   } sq_entry_t;

   // One load pipeline stage
   typedef struct packed {
      logic                 valid;
      logic [TAG_W_DEF-1:0] tag;
   } ld_pipe_t;

endpackage

// File: rtl/dmem_store_queue.sv
// In-order circular store queue with per-entry valid bits and an address CAM.
module dmem_store_queue
   import dmem_lsu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  sq_entry_t                 push_entry,
   input  logic                      pop,
   output sq_entry_t                 head,
   output logic                      full,
   output logic                      empty,
   output logic [CW-1:0]             count,
   input  logic [ADDR_WIDTH_DEF-1:0] match_addr,
   output logic                      match_any
);

   localparam int PW = $clog2(DEPTH);

   sq_entry_t          entries [DEPTH];
   logic [DEPTH-1:0]   vld;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;

   assign head  = entries[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Pointer, count and valid-bit bookkeeping; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld    <= '0;
      end else begin
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Entry payload storage needs no reset; vld qualifies it
   always_ff @(posedge clk) begin
      if (push) entries[wr_ptr] <= push_entry;
   end

   // CAM: does any live entry (head included) hold this address
   always_comb begin
      match_any = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i] && entries[i].addr == match_addr) match_any = 1'b1;
   end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// LSU-to-dmem controller: store queue drain on port 0, tagged 2-cycle loads on port 1,
// and read-after-write hazard blocking so the SRAM never sees a same-address read/write.
module dmem_lsu_ctrl
   import dmem_lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int NUM_WMASKS = NUM_WMASKS_DEF,
   parameter int SQ_DEPTH   = 4,
   parameter int TAG_W      = TAG_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_pause,
   input  logic                  st_valid,
   output logic                  st_ready,
   input  logic [ADDR_WIDTH-1:0] st_addr,
   input  logic [DATA_WIDTH-1:0] st_data,
   input  logic [NUM_WMASKS-1:0] st_mask,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [TAG_W-1:0]      ld_tag,
   output logic                  rsp_valid,
   output logic [TAG_W-1:0]      rsp_tag,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  sq_empty,
   output logic                  mem_csb0,
   output logic [NUM_WMASKS-1:0] mem_wmask0,
   output logic [ADDR_WIDTH-1:0] mem_addr0,
   output logic [DATA_WIDTH-1:0] mem_din0,
   output logic                  mem_csb1,
   output logic [ADDR_WIDTH-1:0] mem_addr1,
   input  logic [DATA_WIDTH-1:0] mem_dout1
);

   localparam int CW = $clog2(SQ_DEPTH) + 1;

   sq_entry_t     sq_head;
   sq_entry_t     sq_in;
   logic          sq_full;
   logic          sq_none;
   logic [CW-1:0] sq_count;
   logic          sq_match;
   logic          st_push;
   logic          wr_drive;
   logic          ld_fire;
   ld_pipe_t      s1;

   assign sq_in = '{addr: st_addr, data: st_data, mask: st_mask};

   // Full queue refuses stores outright; an all-zero mask is accepted but never queued
   assign st_ready = !sq_full;
   assign st_push  = st_valid && st_ready && (st_mask != '0);

   // Head writes the same cycle it is presented; the SRAM captures it at the edge
   assign wr_drive = !sq_none && !wr_pause;

   // Any queued address (including the head being written now) blocks a load;
   // a store arriving this cycle is younger and deliberately not compared
   assign ld_ready = !flush && !sq_match;
   assign ld_fire  = ld_valid && ld_ready;

   assign mem_csb0   = !wr_drive;
   assign mem_wmask0 = wr_drive ? sq_head.mask : '0;
   assign mem_addr0  = wr_drive ? sq_head.addr : '0;
   assign mem_din0   = wr_drive ? sq_head.data : '0;
   assign mem_csb1   = !ld_fire;
   assign mem_addr1  = ld_fire ? ld_addr : '0;

   assign sq_empty = (sq_count == '0) && !wr_drive;

   dmem_store_queue #(.DEPTH(SQ_DEPTH)) u_sq (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (st_push),
      .push_entry (sq_in),
      .pop        (wr_drive),
      .head       (sq_head),
      .full       (sq_full),
      .empty      (sq_none),
      .count      (sq_count),
      .match_addr (ld_addr),
      .match_any  (sq_match)
   );

   // Two-stage load pipe: S1 tracks the tag while the SRAM reads, S2 (rsp) captures dout1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= '0;
         rsp_valid <= 1'b0;
         rsp_tag   <= '0;
         rsp_data  <= '0;
      end else begin
         s1.valid  <= ld_fire;
         s1.tag    <= ld_tag;
         rsp_valid <= s1.valid && !flush;
         if (s1.valid) begin
            rsp_tag  <= s1.tag;
            rsp_data <= mem_dout1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a behavioural dual-port SRAM model.
module tb_dmem_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, wr_pause;
   logic        st_valid, st_ready;
   logic [7:0]  st_addr;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic        ld_valid, ld_ready;
   logic [7:0]  ld_addr;
   logic [5:0]  ld_tag;
   logic        rsp_valid;
   logic [5:0]  rsp_tag;
   logic [31:0] rsp_data;
   logic        sq_empty;
   logic        mem_csb0;
   logic [3:0]  mem_wmask0;
   logic [7:0]  mem_addr0;
   logic [31:0] mem_din0;
   logic        mem_csb1;
   logic [7:0]  mem_addr1;
   logic [31:0] mem_dout1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_lsu_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .wr_pause(wr_pause),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_data(st_data), .st_mask(st_mask),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
      .sq_empty(sq_empty),
      .mem_csb0(mem_csb0), .mem_wmask0(mem_wmask0), .mem_addr0(mem_addr0),
      .mem_din0(mem_din0), .mem_csb1(mem_csb1), .mem_addr1(mem_addr1),
      .mem_dout1(mem_dout1)
   );

   // SRAM model: inputs captured at posedge, write and read performed at the following negedge
   logic [31:0] mem [256];
   logic        w_en, r_en;
   logic [7:0]  w_a, r_a;
   logic [31:0] w_d;
   logic [3:0]  w_m;

   always @(posedge clk) begin
      w_en <= !mem_csb0;
      w_a  <= mem_addr0;
      w_d  <= mem_din0;
      w_m  <= mem_wmask0;
      r_en <= !mem_csb1;
      r_a  <= mem_addr1;
   end

   always @(negedge clk) begin
      if (w_en)
         for (int b = 0; b < 4; b++)
            if (w_m[b]) mem[w_a][b*8 +: 8] <= w_d[b*8 +: 8];
      if (r_en) mem_dout1 <= mem[r_a];
   end

   // Port collision watch: both ports selected must never share an address
   always @(negedge clk) begin
      if (rst_n === 1'b1 && mem_csb0 === 1'b0 && mem_csb1 === 1'b0) begin
         checks++;
         if (mem_addr0 == mem_addr1) begin
            errors++;
            $display("FAIL port_collision: addr0=%h addr1=%h both selected", mem_addr0, mem_addr1);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      flush = 0; wr_pause = 0; st_valid = 0; st_addr = 0; st_data = 0; st_mask = 0;
      ld_valid = 0; ld_addr = 0; ld_tag = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        wp, fl, sv;
      logic [7:0]  sa;
      logic [31:0] sd;
      logic [3:0]  sm;
      logic        lv;
      logic [7:0]  la;
      logic [5:0]  lt;
      logic        e_str, e_ldr, e_csb0;
      logic [7:0]  e_a0;
      logic        e_csb1, e_rv;
      logic [5:0]  e_rt;
      logic [31:0] e_rd;
      logic        e_sqe;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic wp, sv, input logic [7:0] sa, input logic [31:0] sd,
                      input logic [3:0] sm, input logic lv, input logic [7:0] la,
                      input logic [5:0] lt, input logic e_str, e_ldr, e_csb0,
                      input logic [7:0] e_a0, input logic e_csb1, e_rv,
                      input logic [5:0] e_rt, input logic [31:0] e_rd, input logic e_sqe);
      vec_t v;
      v.wp = wp; v.fl = 1'b0; v.sv = sv; v.sa = sa; v.sd = sd; v.sm = sm;
      v.lv = lv; v.la = la; v.lt = lt;
      v.e_str = e_str; v.e_ldr = e_ldr; v.e_csb0 = e_csb0; v.e_a0 = e_a0;
      v.e_csb1 = e_csb1; v.e_rv = e_rv; v.e_rt = e_rt; v.e_rd = e_rd; v.e_sqe = e_sqe;
      vecs.push_back(v);
   endtask

   initial begin
      //      wp sv sa     sd            sm   lv la     lt   str ldr c0 a0     c1 rv rt   rd            sqe
      // full-word store then load of the same word
      add(0, 1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c0
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 0, 8'h10, 1, 0, 6'd0, 32'h0,        0); // c1
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h10, 6'd5, 1, 1, 1, 8'h00, 0, 0, 6'd0, 32'h0,        1); // c2
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c3
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 1, 6'd5, 32'hDEADBEEF, 1); // c4
      // partial-mask store over an all-ones word
      add(0, 1, 8'h20, 32'hFFFFFFFF, 4'hF, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c5
      add(0, 1, 8'h20, 32'h12345678, 4'h3, 0, 8'h00, 6'd0, 1, 1, 0, 8'h20, 1, 0, 6'd0, 32'h0,        0); // c6
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h20, 6'd7, 1, 0, 0, 8'h20, 1, 0, 6'd0, 32'h0,        0); // c7
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h20, 6'd7, 1, 1, 1, 8'h00, 0, 0, 6'd0, 32'h0,        1); // c8
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c9
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 1, 6'd7, 32'hFFFF5678, 1); // c10
      // load colliding with the head being written stalls one cycle
      add(0, 1, 8'h30, 32'hA5A5A5A5, 4'hF, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c11
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h30, 6'd9, 1, 0, 0, 8'h30, 1, 0, 6'd0, 32'h0,        0); // c12
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h30, 6'd9, 1, 1, 1, 8'h00, 0, 0, 6'd0, 32'h0,        1); // c13
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c14
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 1, 6'd9, 32'hA5A5A5A5, 1); // c15
      // paused drain fills the queue; matching load waits, other load goes
      add(1, 1, 8'h40, 32'h40404040, 4'hF, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c16
      add(1, 1, 8'h41, 32'h41414141, 4'hF, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        0); // c17
      add(1, 1, 8'h42, 32'h42424242, 4'hF, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        0); // c18
      add(1, 1, 8'h43, 32'h43434343, 4'hF, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        0); // c19
      add(1, 1, 8'h44, 32'h44444444, 4'hF, 1, 8'h42, 6'd11,0, 0, 1, 8'h00, 1, 0, 6'd0, 32'h0,        0); // c20
      add(1, 0, 8'h00, 32'h0,        4'h0, 1, 8'h10, 6'd12,0, 1, 1, 8'h00, 0, 0, 6'd0, 32'h0,        0); // c21
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h42, 6'd13,0, 0, 0, 8'h40, 1, 0, 6'd0, 32'h0,        0); // c22
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h42, 6'd13,1, 0, 0, 8'h41, 1, 1, 6'd12,32'hDEADBEEF, 0); // c23
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h42, 6'd13,1, 0, 0, 8'h42, 1, 0, 6'd0, 32'h0,        0); // c24
      add(0, 0, 8'h00, 32'h0,        4'h0, 1, 8'h42, 6'd13,1, 1, 0, 8'h43, 0, 0, 6'd0, 32'h0,        0); // c25
      // zero-mask store is accepted but never written
      add(0, 1, 8'h60, 32'h66666666, 4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 0, 6'd0, 32'h0,        1); // c26
      add(0, 0, 8'h00, 32'h0,        4'h0, 0, 8'h00, 6'd0, 1, 1, 1, 8'h00, 1, 1, 6'd13,32'h42424242, 1); // c27

      idle_inputs();
      rst_n = 0;
      #12;
      // reset values
      chk("rst.st_ready", st_ready, 1);   chk("rst.ld_ready", ld_ready, 1);
      chk("rst.rsp_valid", rsp_valid, 0); chk("rst.sq_empty", sq_empty, 1);
      chk("rst.csb0", mem_csb0, 1);       chk("rst.csb1", mem_csb1, 1);
      chk("rst.wmask0", mem_wmask0, 0);
      @(negedge clk); rst_n = 1;

      foreach (vecs[i]) begin
         step();
         wr_pause = vecs[i].wp; flush = vecs[i].fl;
         st_valid = vecs[i].sv; st_addr = vecs[i].sa; st_data = vecs[i].sd; st_mask = vecs[i].sm;
         ld_valid = vecs[i].lv; ld_addr = vecs[i].la; ld_tag = vecs[i].lt;
         @(negedge clk);
         chk($sformatf("v%0d.st_ready", i), st_ready, vecs[i].e_str);
         chk($sformatf("v%0d.ld_ready", i), ld_ready, vecs[i].e_ldr);
         chk($sformatf("v%0d.csb0", i), mem_csb0, vecs[i].e_csb0);
         if (!vecs[i].e_csb0) chk($sformatf("v%0d.addr0", i), mem_addr0, vecs[i].e_a0);
         chk($sformatf("v%0d.csb1", i), mem_csb1, vecs[i].e_csb1);
         chk($sformatf("v%0d.rsp_valid", i), rsp_valid, vecs[i].e_rv);
         if (vecs[i].e_rv) begin
            chk($sformatf("v%0d.rsp_tag", i), rsp_tag, vecs[i].e_rt);
            chk($sformatf("v%0d.rsp_data", i), rsp_data, vecs[i].e_rd);
         end
         chk($sformatf("v%0d.sq_empty", i), sq_empty, vecs[i].e_sqe);
      end

      // Flush: loads tags 1,2 accepted, tag 3 offered with flush; a paused store drains meanwhile
      step(); idle_inputs();
      wr_pause = 1; st_valid = 1; st_addr = 8'h70; st_data = 32'h77777777; st_mask = 4'hF;
      ld_valid = 1; ld_addr = 8'h10; ld_tag = 6'd1;
      @(negedge clk); chk("fl.t1_ready", ld_ready, 1);
      step(); st_valid = 0; ld_tag = 6'd2;
      @(negedge clk); chk("fl.t2_ready", ld_ready, 1); chk("fl.rv0", rsp_valid, 0);
      step(); wr_pause = 0; flush = 1; ld_tag = 6'd3;
      @(negedge clk);
      chk("fl.t3_ready", ld_ready, 0); chk("fl.csb1", mem_csb1, 1);
      chk("fl.t1_rv", rsp_valid, 1);   chk("fl.t1_tag", rsp_tag, 6'd1);
      chk("fl.drain_csb0", mem_csb0, 0); chk("fl.drain_addr0", mem_addr0, 8'h70);
      step(); flush = 0; ld_valid = 0;
      @(negedge clk); chk("fl.no_t2", rsp_valid, 0); chk("fl.sqe", sq_empty, 1);
      step();
      @(negedge clk); chk("fl.no_t3", rsp_valid, 0);
      step(); ld_valid = 1; ld_addr = 8'h70; ld_tag = 6'd4;
      @(negedge clk); chk("fl.t4_ready", ld_ready, 1);
      step(); ld_valid = 0;
      step();
      @(negedge clk); chk("fl.t4_rv", rsp_valid, 1); chk("fl.t4_tag", rsp_tag, 6'd4);
      chk("fl.t4_data", rsp_data, 32'h77777777);

      // Reset mid-operation with 3 queued stores and 2 loads in flight
      step(); idle_inputs(); wr_pause = 1;
      st_valid = 1; st_addr = 8'h80; st_data = 32'h80808080; st_mask = 4'hF;
      step(); st_addr = 8'h81; ld_valid = 1; ld_addr = 8'h10; ld_tag = 6'd20;
      step(); st_addr = 8'h82; ld_tag = 6'd21;
      step(); st_valid = 0; ld_valid = 0;
      @(negedge clk); chk("rm.pre_rv", rsp_valid, 1); chk("rm.pre_sqe", sq_empty, 0);
      #1; idle_inputs(); rst_n = 0;
      #1;
      chk("rm.rsp_valid", rsp_valid, 0); chk("rm.rsp_tag", rsp_tag, 0);
      chk("rm.rsp_data", rsp_data, 0);   chk("rm.csb0", mem_csb0, 1);
      chk("rm.wmask0", mem_wmask0, 0);   chk("rm.addr0", mem_addr0, 0);
      chk("rm.din0", mem_din0, 0);       chk("rm.csb1", mem_csb1, 1);
      chk("rm.addr1", mem_addr1, 0);     chk("rm.st_ready", st_ready, 1);
      chk("rm.ld_ready", ld_ready, 1);   chk("rm.sq_empty", sq_empty, 1);
      @(negedge clk); rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         @(negedge clk);
         chk($sformatf("rm.post%0d_csb0", k), mem_csb0, 1);
         chk($sformatf("rm.post%0d_sqe", k), sq_empty, 1);
         chk($sformatf("rm.post%0d_rv", k), rsp_valid, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
